// File: rtl/c17_bist_ctrl.sv
// BIST controller for the c17 netlist: 5-bit LFSR pattern source, 8-bit MISR response compactor.
// Optional stuck-at injection on cut_in is enabled with `define C17_BIST_STUCK_INJECT_EN.
module c17_bist_ctrl #(
  parameter int unsigned NUM_PATTERNS = 31,
  parameter logic [4:0]  LFSR_SEED    = 5'h01,
  parameter logic [7:0]  GOLDEN_SIG   = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [4:0] cut_in,
  input  logic [1:0] cut_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] signature
`ifdef C17_BIST_STUCK_INJECT_EN
  ,
  input  logic       inj_en,
  input  logic [2:0] inj_bit,
  input  logic       inj_val
`endif
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [7:0] LastCount = 8'(NUM_PATTERNS - 1);

  if (NUM_PATTERNS < 1 || NUM_PATTERNS > 255) begin : gen_bad_patterns
    $error("NUM_PATTERNS must be in 1..255");
  end
  if (LFSR_SEED == 5'h00) begin : gen_bad_seed
    $error("LFSR_SEED must be nonzero");
  end

  logic [1:0] state_q, state_d;
  logic [4:0] lfsr_q, lfsr_d;
  logic [7:0] misr_q, misr_d;
  logic [7:0] cnt_q, cnt_d;
  logic       pass_q, pass_d;

  logic [4:0] lfsr_next;
  logic [7:0] misr_next;

  // x^5+x^3+1 Fibonacci LFSR and x^8+x^6+x^5+x^4+1 MISR with cut_out folded into the low bits.
  always_comb begin
    lfsr_next = {lfsr_q[3:0], lfsr_q[4] ^ lfsr_q[2]};
    misr_next = {misr_q[6:0], misr_q[7] ^ misr_q[5] ^ misr_q[4] ^ misr_q[3]} ^ {6'b0, cut_out};
  end

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    misr_d  = misr_q;
    cnt_d   = cnt_q;
    pass_d  = pass_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d = StRun;
          lfsr_d  = LFSR_SEED;
          misr_d  = 8'h00;
          cnt_d   = 8'h00;
          pass_d  = 1'b0;
        end
      end
      StRun: begin
        misr_d = misr_next;
        lfsr_d = lfsr_next;
        cnt_d  = cnt_q + 8'd1;
        if (cnt_q == LastCount) begin
          state_d = StDone;
          // Judge the signature that includes this final capture.
          pass_d  = (misr_next == GOLDEN_SIG);
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      lfsr_q  <= LFSR_SEED;
      misr_q  <= 8'h00;
      cnt_q   <= 8'h00;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      misr_q  <= misr_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
    end
  end

  assign busy      = (state_q == StRun);
  assign done      = (state_q == StDone);
  assign pass      = done & pass_q;
  assign signature = misr_q;

`ifdef C17_BIST_STUCK_INJECT_EN
  // Emulated stuck-at: override one c17 input; out-of-range bit indices leave cut_in untouched.
  always_comb begin
    cut_in = lfsr_q;
    for (int i = 0; i < 5; i++) begin
      if (inj_en && (inj_bit == 3'(i))) begin
        cut_in[i] = inj_val;
      end
    end
  end
`else
  assign cut_in = lfsr_q;
`endif

endmodule

// File: doc/c17_bist_ctrl.md
# c17_bist_ctrl

Built-in self-test controller for the synthesized c17 benchmark netlist. It drives the five c17 primary inputs from a 5-bit maximal-length LFSR and compacts the two c17 outputs into an 8-bit MISR. After a programmed number of patterns it compares the signature against a golden value. It wraps the combinational c17 instance as the stage directly upstream (pattern source) and downstream (response sink) of it.

## Interface
Parameters:
- NUM_PATTERNS, 31, patterns applied per run; legal range 1..255.
- LFSR_SEED, 5'h01, LFSR start value; must be nonzero.
- GOLDEN_SIG, 8'h00, expected MISR signature at end of run.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset; one clock, asynchronous, active-high.
- start  input  1  begin a run; sampled in IDLE or DONE.
- cut_in  output  5  pattern to the c17 inputs as {N7,N6,N3,N2,N1}.
- cut_out  input  2  c17 response as {N23,N22}.
- busy  output  1  high while in RUN.
- done  output  1  high in DONE.
- pass  output  1  signature == GOLDEN_SIG; valid when done=1, else 0.
- signature  output  8  current MISR contents.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: start=1 moves to RUN, loads LFSR with LFSR_SEED, clears MISR and the 8-bit pattern counter.
- RUN, every cycle:
  - MISR captures cut_out.
  - LFSR advances.
  - Counter increments.
  - When the counter reaches NUM_PATTERNS-1 on a capture edge, move to DONE.
- DONE: done=1; pass and signature hold until the next start. start=1 re-enters RUN with the same reload as from IDLE.
- start in RUN is ignored.
- LFSR (Fibonacci, x^5+x^3+1): fb = q[4]^q[2]; q <= {q[3:0], fb}. Period 31. From seed 5'h01 the sequence is 01, 02, 04, 09, ...
- MISR (x^8+x^6+x^5+x^4+1): m <= {m[6:0], m[7]^m[5]^m[4]^m[3]} ^ {6'b0, cut_out}.
- cut_in is the LFSR register output at all times, so c17 settles within the cycle and no pipeline stage is needed.
- Reset values:
  - state=IDLE, LFSR=LFSR_SEED, MISR=8'h00, counter=0.
  - busy=0, done=0, pass=0, signature=8'h00, cut_in=LFSR_SEED.
- Reset asserted mid-run aborts to the reset values; no partial signature is retained.

## Timing
- start is sampled high at edge k. RUN begins after k with cut_in=LFSR_SEED.
- Captures occur at edges k+1 .. k+NUM_PATTERNS. Capture i uses pattern i-1 of the sequence.
- done=1 and pass become valid after edge k+NUM_PATTERNS. Latency from start is NUM_PATTERNS+1 edges.
- busy=1 exactly over those NUM_PATTERNS cycles.
- pass is registered together with the DONE transition, using the post-capture MISR value.
- Back-to-back runs: start held high in DONE begins the next run on the following edge, and done drops on that same edge.

## Configuration
- Macro C17_BIST_STUCK_INJECT_EN.
- Defined:
  - Adds ports inj_en (input, 1), inj_bit (input, 3), inj_val (input, 1).
  - When inj_en=1 and inj_bit<5, cut_in[inj_bit] is combinationally forced to inj_val. This emulates a stuck-at fault on that c17 input.
  - inj_bit >= 5 has no effect.
- Undefined: these ports do not exist and cut_in is the LFSR output unmodified.

## Test plan
- Reset check: assert rst -> busy=0, done=0, pass=0, signature=8'h00, cut_in=5'h01. Hold start=0 for 10 cycles -> no change.
- NUM_PATTERNS=2, GOLDEN_SIG=8'h03, start pulse -> cut_in 01 then 02; responses 2'b00 then 2'b11; signature=8'h03; done=1 and pass=1 two edges after start.
- Same run with GOLDEN_SIG=8'h02 -> signature=8'h03, pass=0, done=1.
- NUM_PATTERNS=31 -> busy high exactly 31 cycles; cut_in back at 5'h01 when done rises; signature matches a bench model of c17 plus the MISR.
- Abort and restart: assert rst at cycle 10 of a 31-pattern run -> all outputs return to reset values immediately. A second start then gives the same signature as an uninterrupted run.
- With C17_BIST_STUCK_INJECT_EN, NUM_PATTERNS=2, inj_en=1, inj_bit=1, inj_val=0 -> second response is 2'b00, signature=8'h00, pass=0 when GOLDEN_SIG=8'h03.
